// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - load/store unit state encoding, funct3 codes and access-legality helpers
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LSU_TIMEOUT_DEF = 15;

    // Unsigned variants only exist for loads.
    function automatic logic f3_ok(input logic [2:0] f3, input logic load);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return load;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: return lo[0];
            F3_W:        return lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] f3_align_lo(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: return {lo[1], 1'b0};
            F3_W:        return 2'b00;
            default:     return lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - word-wide data memory request/acknowledge bus
interface lsu_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store byte-lane steering and load extraction/extension
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] st_data,
    output logic [31:0] ld_data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sx;

    always_comb begin
        be       = 4'b0000;
        st_data  = 32'h0;
        ld_data  = 32'h0;
        byte_sel = mem_rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        sx       = ~funct3[2];
        // funct3[1:0] gives the size; funct3[2] selects zero extension.
        case (funct3)
            F3_B, F3_BU: begin
                be      = 4'b0001 << addr_lo;
                st_data = {4{wdata[7:0]}};
                ld_data = {{24{sx & byte_sel[7]}}, byte_sel};
            end
            F3_H, F3_HU: begin
                be      = 4'b0011 << {addr_lo[1], 1'b0};
                st_data = {2{wdata[15:0]}};
                ld_data = {{16{sx & half_sel[15]}}, half_sel};
            end
            F3_W: begin
                be      = 4'b1111;
                st_data = wdata;
                ld_data = mem_rdata;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit; define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = LSU_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_en,
    input  logic              st_en,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    lsu_if.master             mem
);
    localparam logic [3:0] TMO = 4'(TIMEOUT);

    lsu_state_e        state_q, state_d;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              is_load_q;
    logic [3:0]        cnt_q;
    logic              req, fault_in, busy, timed_out;
    logic [1:0]        lo_eff;
    logic [3:0]        be;
    logic [31:0]       st_data, ld_data;

    assign req       = ld_en | st_en;
    assign timed_out = cnt_q == TMO;
    assign lo_eff    = f3_align_lo(f3_q, addr_q[1:0]);
    assign stall     = req & ~done;

    // A faulting request never reaches the bus; it goes straight to RESP.
    always_comb begin
        fault_in = !f3_ok(funct3, ld_en);
`ifdef LSU_MISALIGN_TRAP_EN
        fault_in = fault_in | f3_misaligned(funct3, addr[1:0]);
`endif
    end

    lsu_align u_align (
        .funct3    (f3_q),
        .addr_lo   (lo_eff),
        .wdata     (wdata_q),
        .mem_rdata (mem.mem_rdata),
        .be        (be),
        .st_data   (st_data),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= LSU_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: if (req) state_d = fault_in ? LSU_RESP : LSU_BUSY;
            LSU_BUSY: if (mem.mem_ack || timed_out) state_d = LSU_RESP;
            LSU_RESP: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_comb begin
        busy          = state_q == LSU_BUSY;
        mem.mem_req   = busy;
        mem.mem_we    = busy & ~is_load_q;
        mem.mem_addr  = busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        mem.mem_be    = busy ? be : 4'b0000;
        mem.mem_wdata = busy ? st_data : 32'h0;
    end

    // done/err/rdata pulse for the single RESP cycle and are zero otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            f3_q      <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            is_load_q <= 1'b0;
            cnt_q     <= 4'h0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'h0;
        end else begin
            done  <= 1'b0;
            err   <= 1'b0;
            rdata <= 32'h0;
            case (state_q)
                LSU_IDLE: if (req) begin
                    f3_q      <= funct3;
                    addr_q    <= addr;
                    wdata_q   <= wdata;
                    is_load_q <= ld_en;
                    cnt_q     <= 4'h0;
                    if (fault_in) begin
                        done <= 1'b1;
                        err  <= 1'b1;
                    end
                end
                LSU_BUSY: begin
                    if (mem.mem_ack) begin
                        done <= 1'b1;
                        if (is_load_q) rdata <= ld_data;
                    end else if (timed_out) begin
                        done <= 1'b1;
                        err  <= 1'b1;
                    end else if (cnt_q != 4'hF) begin
                        cnt_q <= cnt_q + 4'h1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
